reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter ROB_SIZE_WIDTH, default 4, meaning the width of a RoB entry index (rename tag); the default is `ROB_SIZE_WIDTH from config.v.
REQ-002 SHALL have parameter REG_NUM, default 32, meaning the number of architectural registers.
REQ-003 SHALL use one clock and an asynchronous active-high reset.
REQ-004 Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global ready; when low, no state change.
- clear  in  1  misprediction flush from RoB.
- issue_signal  in  1  decoder issues one instruction this cycle.
- issue_rd  in  5  destination register of the issued instruction; 0 means no rename.
- issue_rob_id  in  ROB_SIZE_WIDTH  RoB entry allocated to the issued instruction.
- commit_rd  in  5  destination register of the committing instruction; 0 means no commit write.
- commit_rob_id  in  ROB_SIZE_WIDTH  RoB entry of the committing instruction.
- commit_value  in  32  committed result.
- rs1, rs2  in  5 each  decoder source-register queries.
- get_rob_id1, get_rob_id2  out  ROB_SIZE_WIDTH each  tag of rs1/rs2, sent to the RoB lookup.
- get_ready1, get_ready2  in  1 each  RoB reports that the tagged value is available.
- get_value1, get_value2  in  32 each  RoB-supplied value.
- val1, val2  out  32 each  resolved operand value.
- dep1, dep2  out  1 each  operand still pending; 1 means use dep_id.
- dep_id1, dep_id2  out  ROB_SIZE_WIDTH each  RoB tag to wait on.

Function
REQ-005 SHALL hold REG_NUM x 32-bit values, with a busy bit and a ROB_SIZE_WIDTH tag per register.
REQ-006 Register x0 SHALL read as 0, SHALL never be busy, and SHALL ignore issue and commit.
REQ-007 The read path SHALL be combinational, with zero latency. For each port n, priority:
- rs==0 -> val=0, dep=0.
- reg not busy -> val=regs[rs], dep=0.
- busy and commit_rd==rs and commit_rob_id==tag -> val=commit_value, dep=0.
- busy and get_ready -> val=get_value, dep=0.
- otherwise -> dep=1, dep_id=tag, val=0.
REQ-008 get_rob_idN SHALL equal tag[rsN] at all times.
REQ-009 Reads SHALL see pre-issue state: an issue to the same register in the same cycle SHALL NOT affect that cycle's outputs.
REQ-010 Commit (rdy=1, commit_rd!=0): regs[commit_rd] SHALL take commit_value at the next edge.
- busy[commit_rd] SHALL clear only if tag==commit_rob_id and no same-cycle issue targets commit_rd.
REQ-011 Issue (rdy=1, clear=0, issue_signal=1, issue_rd!=0): tag[issue_rd] SHALL take issue_rob_id and busy SHALL be set.
REQ-012 Issue and commit to the same rd in the same cycle: the value SHALL be written, tag SHALL take issue_rob_id, and busy SHALL remain 1.
REQ-013 clear with rdy=1 SHALL clear every busy bit at the next edge.
- Values SHALL be retained.
- A same-cycle commit SHALL still write its value.
- A same-cycle issue SHALL be discarded.
REQ-014 With rdy=0, no register, busy or tag state SHALL change; combinational outputs SHALL still track inputs.

Reset
REQ-015 rst SHALL asynchronously set all values to 0, all busy bits to 0 and all tags to 0.
- Outputs after reset: val=0, dep=0, dep_id=0, get_rob_id=0.
REQ-016 Reset asserted mid-operation SHALL override any pending issue, commit or clear.

Structure
REQ-017 ROB_SIZE_WIDTH and REG_NUM SHALL come from the shared config.v.
REQ-018 Implementation SHALL be a single module: one read-resolve function instantiated per port, and no sub-modules.

Verification
REQ-019 Directed scenarios:
- Reset, then rs1=5 -> val1=0, dep1=0.
- Issue rd=5 rob 3; next cycle rs1=5 with get_ready1=0 -> dep1=1, dep_id1=3, get_rob_id1=3.
- Same state, get_ready1=1, get_value1=0x1234 -> val1=0x1234, dep1=0.
- Commit rd=5 rob 3 value 0xAA; in the same cycle rs2=5 -> val2=0xAA, dep2=0; next cycle busy clear, val2=0xAA.
- Issue rd=5 rob 3, then issue rd=5 rob 7, then commit rd=5 rob 3 -> value updated, dep=1, dep_id=7.
- Same-cycle commit rd=6 rob 2 and issue rd=6 rob 4 -> value written, dep_id=4 next cycle.
- clear with pending tags -> all dep=0 next cycle, values unchanged.
- rdy=0 during issue -> no tag change.
- Commit rd=0 value 0x55 -> x0 reads 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared sizing defaults and the per-port operand resolve helper for the rename register file.
package reg_file_pkg;

  localparam int RF_ROB_SIZE_WIDTH = 4;
  localparam int RF_REG_NUM        = 32;

  typedef struct packed {
    logic [31:0] val;
    logic        dep;
  } rd_res_t;

  // Bypass priority: x0, settled register, same-cycle commit, RoB-held value, then wait on the tag.
  function automatic rd_res_t rd_resolve(
    input logic        is_x0,
    input logic        busy,
    input logic [31:0] reg_val,
    input logic        cmt_hit,
    input logic [31:0] cmt_val,
    input logic        rob_ready,
    input logic [31:0] rob_val
  );
    rd_res_t r;
    r.val = '0;
    r.dep = 1'b0;
    if (is_x0)          r.val = '0;
    else if (!busy)     r.val = reg_val;
    else if (cmt_hit)   r.val = cmt_val;
    else if (rob_ready) r.val = rob_val;
    else                r.dep = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file with rename tags; combinational operand resolve against commit and RoB.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_SIZE_WIDTH = RF_ROB_SIZE_WIDTH,
  parameter int REG_NUM        = RF_REG_NUM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      issue_signal,
  input  logic [4:0]                issue_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic [4:0]                commit_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  input  logic [31:0]               commit_value,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  output logic [ROB_SIZE_WIDTH-1:0] get_rob_id1,
  output logic [ROB_SIZE_WIDTH-1:0] get_rob_id2,
  input  logic                      get_ready1,
  input  logic                      get_ready2,
  input  logic [31:0]               get_value1,
  input  logic [31:0]               get_value2,
  output logic [31:0]               val1,
  output logic [31:0]               val2,
  output logic                      dep1,
  output logic                      dep2,
  output logic [ROB_SIZE_WIDTH-1:0] dep_id1,
  output logic [ROB_SIZE_WIDTH-1:0] dep_id2
);

  logic [31:0]               r_val  [REG_NUM];
  logic [ROB_SIZE_WIDTH-1:0] r_tag  [REG_NUM];
  logic [REG_NUM-1:0]        r_busy;

  logic    w_iss, w_cmt, w_cmt_clr;
  rd_res_t w_res1, w_res2;

  assign w_iss = rdy && !clear && issue_signal && (issue_rd != 5'd0);
  assign w_cmt = rdy && (commit_rd != 5'd0);
  // A younger issue to the same rd keeps the register busy under its new tag.
  assign w_cmt_clr = w_cmt && r_busy[commit_rd] && (r_tag[commit_rd] == commit_rob_id)
                     && !(w_iss && (issue_rd == commit_rd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
      r_busy <= '0;
    end else if (rdy) begin
      if (w_cmt) r_val[commit_rd] <= commit_value;
      if (clear) begin
        r_busy <= '0;
      end else begin
        if (w_cmt_clr) r_busy[commit_rd] <= 1'b0;
        if (w_iss) begin
          r_busy[issue_rd] <= 1'b1;
          r_tag[issue_rd]  <= issue_rob_id;
        end
      end
    end
  end

  assign get_rob_id1 = r_tag[rs1];
  assign get_rob_id2 = r_tag[rs2];

  always_comb begin
    w_res1 = rd_resolve(rs1 == 5'd0, r_busy[rs1], r_val[rs1],
                        (commit_rd == rs1) && (commit_rob_id == r_tag[rs1]), commit_value,
                        get_ready1, get_value1);
    w_res2 = rd_resolve(rs2 == 5'd0, r_busy[rs2], r_val[rs2],
                        (commit_rd == rs2) && (commit_rob_id == r_tag[rs2]), commit_value,
                        get_ready2, get_value2);
  end

  assign val1    = w_res1.val;
  assign dep1    = w_res1.dep;
  assign dep_id1 = w_res1.dep ? r_tag[rs1] : '0;
  assign val2    = w_res2.val;
  assign dep2    = w_res2.dep;
  assign dep_id2 = w_res2.dep ? r_tag[rs2] : '0;

endmodule

// File: tb/tb_reg_file.sv
// Directed plus randomized check of reg_file against an array-based reference model.
module tb_reg_file;
  localparam int RW = 4;

  logic          clk, rst, rdy, clear, issue_signal;
  logic [4:0]    issue_rd, commit_rd, rs1, rs2;
  logic [RW-1:0] issue_rob_id, commit_rob_id;
  logic [31:0]   commit_value, get_value1, get_value2;
  logic          get_ready1, get_ready2;
  logic [RW-1:0] get_rob_id1, get_rob_id2, dep_id1, dep_id2;
  logic [31:0]   val1, val2;
  logic          dep1, dep2;

  reg_file #(.ROB_SIZE_WIDTH(RW), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_signal(issue_signal), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .commit_rd(commit_rd), .commit_rob_id(commit_rob_id), .commit_value(commit_value),
    .rs1(rs1), .rs2(rs2), .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
    .get_ready1(get_ready1), .get_ready2(get_ready2),
    .get_value1(get_value1), .get_value2(get_value2),
    .val1(val1), .val2(val2), .dep1(dep1), .dep2(dep2),
    .dep_id1(dep_id1), .dep_id2(dep_id2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0]   m_val  [32];
  logic          m_busy [32];
  logic [RW-1:0] m_tag  [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  endtask

  // Architectural effect of one clock edge, read off the current inputs.
  task automatic m_step();
    logic iss;
    iss = rdy && !clear && issue_signal && (issue_rd != 0);
    if (!rdy) return;
    if (commit_rd != 0) begin
      if (m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_id && !(iss && issue_rd == commit_rd))
        m_busy[commit_rd] = 1'b0;
      m_val[commit_rd] = commit_value;
    end
    if (clear) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    if (iss) begin
      m_busy[issue_rd] = 1'b1;
      m_tag[issue_rd]  = issue_rob_id;
    end
  endtask

  task automatic exp_rd(input logic [4:0] rs, input logic gr, input logic [31:0] gv,
                        output logic [31:0] v, output logic d);
    v = '0; d = 1'b0;
    if (rs == 0)                                              v = '0;
    else if (!m_busy[rs])                                     v = m_val[rs];
    else if (commit_rd == rs && commit_rob_id == m_tag[rs])   v = commit_value;
    else if (gr)                                              v = gv;
    else                                                      d = 1'b1;
  endtask

  task automatic check_all();
    logic [31:0] v; logic d;
    exp_rd(rs1, get_ready1, get_value1, v, d);
    chk("val1", val1, v);
    chk("dep1", {31'd0, dep1}, {31'd0, d});
    if (d) chk("dep_id1", {28'd0, dep_id1}, {28'd0, m_tag[rs1]});
    chk("get_rob_id1", {28'd0, get_rob_id1}, {28'd0, m_tag[rs1]});
    exp_rd(rs2, get_ready2, get_value2, v, d);
    chk("val2", val2, v);
    chk("dep2", {31'd0, dep2}, {31'd0, d});
    if (d) chk("dep_id2", {28'd0, dep_id2}, {28'd0, m_tag[rs2]});
    chk("get_rob_id2", {28'd0, get_rob_id2}, {28'd0, m_tag[rs2]});
  endtask

  task automatic idle();
    rdy = 1'b1; clear = 1'b0; issue_signal = 1'b0; issue_rd = '0; issue_rob_id = '0;
    commit_rd = '0; commit_rob_id = '0; commit_value = '0; rs1 = '0; rs2 = '0;
    get_ready1 = 1'b0; get_ready2 = 1'b0; get_value1 = '0; get_value2 = '0;
  endtask

  task automatic settle(); #1; endtask

  task automatic tick();
    check_all();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rd, input logic [RW-1:0] id);
    idle(); issue_signal = 1'b1; issue_rd = rd; issue_rob_id = id; settle(); tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    idle(); rs1 = 5; rs2 = 9; settle();
    chk("rst_val1", val1, 32'd0);
    chk("rst_dep1", {31'd0, dep1}, 32'd0);
    chk("rst_robid2", {28'd0, get_rob_id2}, 32'd0);
    tick();

    issue(5, 3);
    idle(); rs1 = 5; settle();
    chk("pend_dep1", {31'd0, dep1}, 32'd1);
    chk("pend_depid1", {28'd0, dep_id1}, 32'd3);
    chk("pend_robid1", {28'd0, get_rob_id1}, 32'd3);
    tick();

    idle(); rs1 = 5; get_ready1 = 1'b1; get_value1 = 32'h1234; settle();
    chk("robfwd_val1", val1, 32'h1234);
    chk("robfwd_dep1", {31'd0, dep1}, 32'd0);
    tick();

    idle(); commit_rd = 5; commit_rob_id = 3; commit_value = 32'hAA; rs2 = 5; settle();
    chk("cmtfwd_val2", val2, 32'hAA);
    chk("cmtfwd_dep2", {31'd0, dep2}, 32'd0);
    tick();
    idle(); rs2 = 5; settle();
    chk("cmt_val2", val2, 32'hAA);
    chk("cmt_dep2", {31'd0, dep2}, 32'd0);
    tick();

    // stale commit must not release a re-renamed register
    issue(5, 3);
    issue(5, 7);
    idle(); commit_rd = 5; commit_rob_id = 3; commit_value = 32'hBB; settle(); tick();
    idle(); rs1 = 5; settle();
    chk("stale_dep1", {31'd0, dep1}, 32'd1);
    chk("stale_depid1", {28'd0, dep_id1}, 32'd7);
    tick();

    idle(); commit_rd = 6; commit_rob_id = 2; commit_value = 32'h66;
    issue_signal = 1'b1; issue_rd = 6; issue_rob_id = 4; settle(); tick();
    idle(); rs1 = 6; settle();
    chk("same_dep1", {31'd0, dep1}, 32'd1);
    chk("same_depid1", {28'd0, dep_id1}, 32'd4);
    tick();

    // clear keeps values, drops a concurrent issue
    idle(); clear = 1'b1; issue_signal = 1'b1; issue_rd = 8; issue_rob_id = 5; settle(); tick();
    idle(); rs1 = 5; rs2 = 6; settle();
    chk("clr_val1", val1, 32'hBB);
    chk("clr_dep1", {31'd0, dep1}, 32'd0);
    chk("clr_val2", val2, 32'h66);
    chk("clr_dep2", {31'd0, dep2}, 32'd0);
    tick();
    idle(); rs1 = 8; settle();
    chk("clr_iss_dep1", {31'd0, dep1}, 32'd0);
    tick();

    idle(); rdy = 1'b0; issue_signal = 1'b1; issue_rd = 7; issue_rob_id = 9; settle(); tick();
    idle(); rs1 = 7; settle();
    chk("rdy0_dep1", {31'd0, dep1}, 32'd0);
    chk("rdy0_robid1", {28'd0, get_rob_id1}, 32'd0);
    tick();

    idle(); commit_rd = 0; commit_value = 32'h55; settle(); tick();
    idle(); rs1 = 0; settle();
    chk("x0_val1", val1, 32'd0);
    chk("x0_dep1", {31'd0, dep1}, 32'd0);
    tick();

    // asynchronous reset mid-operation beats a pending issue
    issue(5, 9);
    idle(); issue_signal = 1'b1; issue_rd = 5; issue_rob_id = 2; rs1 = 5; rs2 = 6;
    #2 rst = 1'b1; m_reset();
    #1;
    chk("arst_dep1", {31'd0, dep1}, 32'd0);
    chk("arst_robid1", {28'd0, get_rob_id1}, 32'd0);
    chk("arst_val2", val2, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    for (int n = 0; n < 600; n++) begin
      idle();
      rdy          = ($urandom_range(9) != 0);
      clear        = ($urandom_range(19) == 0);
      issue_signal = ($urandom_range(9) < 6);
      issue_rd     = 5'($urandom_range(7));
      issue_rob_id = RW'($urandom);
      commit_rd    = 5'($urandom_range(7));
      commit_rob_id = ($urandom_range(1) == 0) ? m_tag[commit_rd] : RW'($urandom);
      commit_value = $urandom;
      rs1          = 5'($urandom_range(7));
      rs2          = 5'($urandom_range(7));
      get_ready1   = $urandom_range(1) == 1;
      get_ready2   = $urandom_range(1) == 1;
      get_value1   = $urandom;
      get_value2   = $urandom;
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
